// File: rtl/ber_meas_ctrl_pkg.sv
// Shared types and constants for the BER measurement sequencer.
// The state encoding is visible to the VIO on o_state, so its values are fixed.
package ber_ctrl_pkg;

    localparam int CNT_W = 64;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } state_e;

    // The counters run only while phase search or measurement is active.
    function automatic logic is_counting(input state_e s);
        return (s == ST_SEARCH) || (s == ST_MEASURE);
    endfunction

endpackage

// File: rtl/ber_meas_ctrl_if.sv
// Control, status and count bundle between the VIO/BER counters and the sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface ber_meas_ctrl_if;
    import ber_ctrl_pkg::*;

    logic       i_enable;
    logic       i_start;
    logic       i_stop;
    logic       i_phase_ok_i;
    logic       i_phase_ok_q;
    cnt_t       i_bits_i;
    cnt_t       i_errs_i;
    cnt_t       i_bits_q;
    cnt_t       i_errs_q;

    logic       o_ber_reset;
    logic       o_ber_enable;
    logic [2:0] o_state;
    logic       o_done;
    logic       o_timeout;
    cnt_t       o_snap_bits_i;
    cnt_t       o_snap_errs_i;
    cnt_t       o_snap_bits_q;
    cnt_t       o_snap_errs_q;

    modport slave (
        input  i_enable, i_start, i_stop, i_phase_ok_i, i_phase_ok_q,
        input  i_bits_i, i_errs_i, i_bits_q, i_errs_q,
        output o_ber_reset, o_ber_enable, o_state, o_done, o_timeout,
        output o_snap_bits_i, o_snap_errs_i, o_snap_bits_q, o_snap_errs_q
    );

    modport master (
        output i_enable, i_start, i_stop, i_phase_ok_i, i_phase_ok_q,
        output i_bits_i, i_errs_i, i_bits_q, i_errs_q,
        input  o_ber_reset, o_ber_enable, o_state, o_done, o_timeout,
        input  o_snap_bits_i, o_snap_errs_i, o_snap_bits_q, o_snap_errs_q
    );

endinterface

// File: rtl/ber_meas_ctrl_snapshot_reg.sv
// Four count snapshot registers loaded together on one strobe.
// Word order: [0] bits_i, [1] errs_i, [2] bits_q, [3] errs_q.
module ber_snapshot_reg
    import ber_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [3:0][CNT_W-1:0] d,
    output logic [3:0][CNT_W-1:0] q
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        cnt_t word_d;
        cnt_t word_q;

        always_comb begin
            word_d = word_q;
            if (load) begin
                word_d = d[gi];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end

        assign q[gi] = word_q;
    end

endmodule

// File: rtl/ber_meas_ctrl.sv
// Run sequencer for the I/Q BER counters: clear, phase search with timeout,
// measure to a bit budget (or graceful stop), then freeze a count snapshot.
module ber_meas_ctrl
    import ber_ctrl_pkg::*;
#(
    parameter int               CLR_CYCLES = 4,
    parameter int               TMO_W      = 32,
    parameter logic [TMO_W-1:0] SEARCH_TMO = 32'd16777216,
    parameter logic [CNT_W-1:0] MEAS_BITS  = 64'd1000000
) (
    input  logic           clock,
    input  logic           i_reset,
    ber_meas_ctrl_if.slave bus
);

    localparam int               CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = SEARCH_TMO - TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

    state_e             state_q, state_d;
    logic [CLR_W-1:0]   clr_q, clr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               ber_reset_q, ber_reset_d;
    logic               ber_enable_q, ber_enable_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               snap_load;
    logic [3:0][CNT_W-1:0] snap_in;
    logic [3:0][CNT_W-1:0] snap_out;

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        tmo_d     = tmo_q;
        snap_load = 1'b0;

        if (!bus.i_enable) begin
            state_d = ST_IDLE;
            clr_d   = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    // A simultaneous stop suppresses the start.
                    if (bus.i_start && !bus.i_stop) begin
                        state_d = ST_CLEAR;
                        clr_d   = '0;
                    end
                end
                ST_CLEAR: begin
                    if (bus.i_stop) begin
                        state_d = ST_IDLE;
                        clr_d   = '0;
                        tmo_d   = '0;
                    end else if (clr_q == CLR_LAST) begin
                        state_d = ST_SEARCH;
                        clr_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        clr_d = clr_q + CLR_W'(1);
                    end
                end
                ST_SEARCH: begin
                    if (bus.i_stop) begin
                        state_d = ST_IDLE;
                        clr_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
                        // Phase lock is checked first so it beats a same-cycle timeout.
                        if (bus.i_phase_ok_i && bus.i_phase_ok_q) begin
                            state_d = ST_MEASURE;
                        end else if (tmo_q == TMO_LAST) begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (bus.i_stop || (bus.i_bits_i >= MEAS_BITS)) begin
                        state_d   = ST_DONE;
                        snap_load = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    clr_d   = '0;
                    tmo_d   = '0;
                end
            endcase
        end

        // Status outputs are registered from the next state so they switch on
        // the same edge as o_state and never glitch.
        ber_reset_d  = (state_d == ST_CLEAR);
        ber_enable_d = is_counting(state_d);
        done_d       = (state_d == ST_DONE);
        timeout_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            clr_q        <= '0;
            tmo_q        <= '0;
            ber_reset_q  <= 1'b0;
            ber_enable_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_q        <= clr_d;
            tmo_q        <= tmo_d;
            ber_reset_q  <= ber_reset_d;
            ber_enable_q <= ber_enable_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign snap_in = {bus.i_errs_q, bus.i_bits_q, bus.i_errs_i, bus.i_bits_i};

    ber_snapshot_reg u_snap (
        .clk   (clock),
        .rst_n (i_reset),
        .load  (snap_load),
        .d     (snap_in),
        .q     (snap_out)
    );

    assign bus.o_ber_reset   = ber_reset_q;
    assign bus.o_ber_enable  = ber_enable_q;
    assign bus.o_state       = state_q;
    assign bus.o_done        = done_q;
    assign bus.o_timeout     = timeout_q;
    assign bus.o_snap_bits_i = snap_out[0];
    assign bus.o_snap_errs_i = snap_out[1];
    assign bus.o_snap_bits_q = snap_out[2];
    assign bus.o_snap_errs_q = snap_out[3];

endmodule

// File: tb/tb_ber_meas_ctrl.sv
// Self-checking bench for ber_meas_ctrl: each run is predicted from phase
// durations and ramp arithmetic, then compared against the DUT outputs.
module tb_ber_meas_ctrl;
    import ber_ctrl_pkg::*;

    localparam int          CLR = 4;
    localparam int          TMO = 50;
    localparam logic [63:0] MB  = 64'd1000;

    logic clock   = 1'b0;
    logic i_reset = 1'b0;
    always #5 clock = ~clock;

    ber_meas_ctrl_if bus ();

    ber_meas_ctrl #(
        .CLR_CYCLES (CLR),
        .TMO_W      (32),
        .SEARCH_TMO (32'd50),
        .MEAS_BITS  (64'd1000)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] snap_exp [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic chk_snaps(input string tag);
        chk({tag, "_snap_bits_i"}, bus.o_snap_bits_i, snap_exp[0]);
        chk({tag, "_snap_errs_i"}, bus.o_snap_errs_i, snap_exp[1]);
        chk({tag, "_snap_bits_q"}, bus.o_snap_bits_q, snap_exp[2]);
        chk({tag, "_snap_errs_q"}, bus.o_snap_errs_q, snap_exp[3]);
    endtask

    // Start from IDLE/DONE/FAIL; return at the first SEARCH cycle.
    task automatic start_run(input string tag);
        int n;
        bus.i_phase_ok_i = 1'b0;
        bus.i_phase_ok_q = 1'b0;
        bus.i_start      = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk({tag, "_clr_entry_done"}, bus.o_done, 0);
        chk({tag, "_clr_entry_state"}, bus.o_state, 1);
        n = 0;
        while (bus.o_ber_reset === 1'b1 && n < 100) begin
            chk({tag, "_clr_enable"}, bus.o_ber_enable, 0);
            n++;
            tick();
        end
        chk({tag, "_clr_len"}, n, CLR);
        chk({tag, "_search_state"}, bus.o_state, 2);
        chk({tag, "_search_enable"}, bus.o_ber_enable, 1);
        $display("run %s: clear held %0d cycles", tag, n);
    endtask

    // Phase flags rise at search cycles di/dq; returns 1 if MEASURE is reached.
    task automatic search_phase(input string tag, input int di, input int dq, output bit measured);
        int n, m, exp_len;
        m        = (di > dq) ? di : dq;
        measured = (m <= TMO - 1);
        exp_len  = measured ? m + 1 : TMO;
        n = 0;
        while (bus.o_state === 3'd2 && n < 200) begin
            bus.i_phase_ok_i = (n >= di);
            bus.i_phase_ok_q = (n >= dq);
            n++;
            tick();
        end
        chk({tag, "_search_len"}, n, exp_len);
        chk({tag, "_post_search_state"}, bus.o_state, measured ? 3 : 5);
        chk({tag, "_timeout"}, bus.o_timeout, measured ? 0 : 1);
        if (!measured) begin
            chk({tag, "_fail_enable"}, bus.o_ber_enable, 0);
            chk_snaps({tag, "_fail"});
        end
        $display("run %s: search di=%0d dq=%0d lasted %0d cycles -> state %0d",
                 tag, di, dq, n, bus.o_state);
    endtask

    // bits_i ramps start + step*j; optional stop at ramp index stop_j.
    task automatic measure_phase(input string tag, input logic [63:0] start, input int step,
                                 input bit use_stop, input int stop_j,
                                 input logic [63:0] ei, input logic [63:0] bq, input logic [63:0] eq);
        int jstar, n;
        jstar = -1;
        for (int j = 0; j < 3000 && jstar < 0; j++) begin
            if ((start + 64'(step) * 64'(j)) >= MB || (use_stop && j == stop_j)) jstar = j;
        end
        bus.i_errs_i = ei;
        bus.i_bits_q = bq;
        bus.i_errs_q = eq;
        n = 0;
        while (bus.o_state === 3'd3 && n < 3000) begin
            bus.i_bits_i = start + 64'(step) * 64'(n);
            bus.i_stop   = use_stop && (n == stop_j);
            n++;
            tick();
        end
        bus.i_stop = 1'b0;
        snap_exp[0] = start + 64'(step) * 64'(jstar);
        snap_exp[1] = ei;
        snap_exp[2] = bq;
        snap_exp[3] = eq;
        chk({tag, "_meas_len"}, n, jstar + 1);
        chk({tag, "_done_state"}, bus.o_state, 4);
        chk({tag, "_done_flag"}, bus.o_done, 1);
        chk({tag, "_done_enable"}, bus.o_ber_enable, 0);
        chk_snaps({tag, "_done"});
        // Live counts keep moving but the snapshot must hold.
        bus.i_bits_i = bus.i_bits_i + 64'd77;
        bus.i_errs_q = ~eq;
        tick();
        chk_snaps({tag, "_hold"});
        $display("run %s: measure %0d cycles, snap bits_i=%0d errs_i=%0d bits_q=%0d errs_q=%0d",
                 tag, n, bus.o_snap_bits_i, bus.o_snap_errs_i, bus.o_snap_bits_q, bus.o_snap_errs_q);
    endtask

    initial begin
        bit measured;
        bus.i_enable     = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_stop       = 1'b0;
        bus.i_phase_ok_i = 1'b0;
        bus.i_phase_ok_q = 1'b0;
        bus.i_bits_i     = '0;
        bus.i_errs_i     = '0;
        bus.i_bits_q     = '0;
        bus.i_errs_q     = '0;
        for (int k = 0; k < 4; k++) snap_exp[k] = '0;

        #7;
        chk("rst_state", bus.o_state, 0);
        chk("rst_ber_reset", bus.o_ber_reset, 0);
        chk("rst_enable", bus.o_ber_enable, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_timeout", bus.o_timeout, 0);
        chk_snaps("rst");
        tick();
        i_reset = 1'b1;
        tick();
        tick();
        chk("idle_state", bus.o_state, 0);

        // Search timeout with no phase lock: snapshots stay zero.
        start_run("tmo");
        search_phase("tmo", 1000, 1000, measured);

        // Directed ramp to the bit budget, starting from FAIL.
        start_run("ramp");
        search_phase("ramp", 10, 20, measured);
        if (measured) measure_phase("ramp", 64'd0, 1, 1'b0, 0, 64'd7, 64'd998, 64'd3);

        // Start and stop together in DONE: state holds.
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        chk("startstop_state", bus.o_state, 4);
        chk("startstop_done", bus.o_done, 1);
        $display("start+stop in DONE: state %0d", bus.o_state);

        // Phase lock on the terminal timeout cycle; then graceful stop at 400.
        start_run("tie");
        search_phase("tie", 49, 49, measured);
        if (measured) measure_phase("tie", 64'd0, 100, 1'b1, 4, 64'd11, 64'd402, 64'd5);

        // Stop during SEARCH returns to IDLE without a snapshot.
        start_run("sstop");
        tick();
        tick();
        bus.i_stop = 1'b1;
        tick();
        bus.i_stop = 1'b0;
        chk("sstop_state", bus.o_state, 0);
        chk("sstop_enable", bus.o_ber_enable, 0);
        chk_snaps("sstop");
        $display("stop in SEARCH: state %0d", bus.o_state);

        // Unsigned compare: a top-bit-set count ends measurement at once.
        start_run("big");
        search_phase("big", 0, 3, measured);
        if (measured) measure_phase("big", 64'h8000_0000_0000_0000, 1, 1'b0, 0, 64'd1, 64'd2, 64'd3);

        // Dropping enable in DONE forces IDLE, keeps snapshots, drops o_done.
        bus.i_enable = 1'b0;
        tick();
        chk("en_state", bus.o_state, 0);
        chk("en_done", bus.o_done, 0);
        chk_snaps("en");
        bus.i_enable = 1'b1;
        bus.i_start  = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk("en_restart_state", bus.o_state, 1);
        // Enable drop mid-CLEAR aborts the run.
        bus.i_enable = 1'b0;
        tick();
        chk("en_clr_state", bus.o_state, 0);
        chk("en_clr_reset", bus.o_ber_reset, 0);
        bus.i_enable = 1'b1;
        tick();
        $display("enable drop: state %0d", bus.o_state);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int          di, dq, step, stop_j;
            bit          use_stop;
            logic [63:0] st;
            di       = $urandom_range(0, 60);
            dq       = $urandom_range(0, 60);
            st       = 64'($urandom_range(0, 900));
            step     = $urandom_range(1, 40);
            use_stop = 1'($urandom_range(0, 1));
            stop_j   = $urandom_range(0, 30);
            start_run($sformatf("rnd%0d", r));
            search_phase($sformatf("rnd%0d", r), di, dq, measured);
            if (measured) begin
                measure_phase($sformatf("rnd%0d", r), st, step, use_stop, stop_j,
                              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            end
        end

        // Asynchronous reset in the middle of MEASURE.
        start_run("arst");
        search_phase("arst", 0, 0, measured);
        bus.i_bits_i = 64'd5;
        tick();
        tick();
        chk("arst_pre_state", bus.o_state, 3);
        #2;
        i_reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) snap_exp[k] = '0;
        chk("arst_state", bus.o_state, 0);
        chk("arst_ber_reset", bus.o_ber_reset, 0);
        chk("arst_enable", bus.o_ber_enable, 0);
        chk("arst_done", bus.o_done, 0);
        chk("arst_timeout", bus.o_timeout, 0);
        chk_snaps("arst");
        $display("async reset mid-MEASURE: state %0d enable %0d", bus.o_state, bus.o_ber_enable);
        tick();
        i_reset = 1'b1;
        tick();
        chk("arst_post_state", bus.o_state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
